// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit and its decode-side interface.
package common;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_type;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// Circular instruction buffer: push 0/1/2, pop 0/1/2, synchronous clear.
// Head entries read as all-zero when not occupied.
module if_instr_queue
    import common::*;
#(
    parameter  int QDEPTH = 8,
    localparam int PTRW   = $clog2(QDEPTH),
    localparam int CW     = PTRW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [1:0]    push_cnt,
    input  if_id_type     push0,
    input  if_id_type     push1,
    input  logic [1:0]    pop_cnt,
    output if_id_type     head0,
    output if_id_type     head1,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free
);

    if_id_type         mem [QDEPTH];
    logic [PTRW-1:0]   rd_ptr;
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr1;
    logic [PTRW-1:0]   wr_ptr1;

    assign rd_ptr1 = rd_ptr + PTRW'(1);
    assign wr_ptr1 = wr_ptr + PTRW'(1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTRW'(pop_cnt);
            wr_ptr <= wr_ptr + PTRW'(push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            if (push_cnt != 2'd0) mem[wr_ptr]  <= push0;
            if (push_cnt == 2'd2) mem[wr_ptr1] <= push1;
        end
    end

    assign head0 = (count != '0)      ? mem[rd_ptr]  : '0;
    assign head1 = (count >= CW'(2))  ? mem[rd_ptr1] : '0;
    assign free  = CW'(QDEPTH) - count;

endmodule

// File: rtl/if_fetch_unit.sv
// Dual-issue fetch: one outstanding 64-bit line request, queue, two-wide output to decode.
// Optional IF_FETCH_PERF_EN adds saturating stall/flush counters.
//   state | meaning
//   REQ   | request next line when the queue has room for two
//   WAIT  | request accepted, response will be pushed
//   DROP  | request accepted before a redirect, response will be discarded
module if_fetch_unit
    import common::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output if_id_type   if_instr0,
    output if_id_type   if_instr1
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state, state_nx;
    logic [31:0]   fetch_pc, fetch_pc_nx;
    logic [31:0]   line;
    logic          req_fire;
    logic          q_clear;
    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    if_id_type     push0, push1;
    logic [CW-1:0] q_count, q_free;
    logic          redir_lsb_unused;

    // Redirect targets are word-aligned; the low two bits carry no meaning.
    assign redir_lsb_unused = ^redirect_pc[1:0];

    assign line          = line_of(fetch_pc);
    assign imem_req_addr = line;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        q_clear        = 1'b0;
        push_cnt       = 2'd0;
        push0          = '0;
        push1          = '0;

        case (state)
            REQ: begin
                // Pre-pop free count, so an accepted line always fits.
                imem_req_valid = !reset && (q_free >= CW'(2));
                req_fire       = imem_req_valid && imem_req_ready;
                if (req_fire) state_nx = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_nx    = REQ;
                    fetch_pc_nx = {fetch_pc[31:3] + 29'd1, 3'b000};
                    if (!fetch_pc[2]) begin
                        push_cnt = 2'd2;
                        push0    = '{valid: 1'b1, pc: line, instr: imem_resp_data[31:0]};
                        push1    = '{valid: 1'b1, pc: {line[31:3], 3'(INSTR_BYTES)},
                                     instr: imem_resp_data[63:32]};
                    end else begin
                        push_cnt = 2'd1;
                        push0    = '{valid: 1'b1, pc: {line[31:3], 3'(INSTR_BYTES)},
                                     instr: imem_resp_data[63:32]};
                    end
                end
            end
            DROP: begin
                if (imem_resp_valid) state_nx = REQ;
            end
            default: state_nx = REQ;
        endcase

        // A request that is outstanding after this edge must be drained in DROP.
        if (redirect_valid) begin
            q_clear     = 1'b1;
            push_cnt    = 2'd0;
            fetch_pc_nx = {redirect_pc[31:2], 2'b00};
            if (state == REQ) state_nx = req_fire ? DROP : REQ;
            else              state_nx = imem_resp_valid ? REQ : DROP;
        end
    end

    always_comb begin
        pop_cnt = 2'd0;
        if (id_ready && !redirect_valid) begin
            if (q_count >= CW'(2))     pop_cnt = 2'd2;
            else if (q_count != '0)    pop_cnt = 2'd1;
        end
    end

    if_instr_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (q_clear),
        .push_cnt (push_cnt),
        .push0    (push0),
        .push1    (push1),
        .pop_cnt  (pop_cnt),
        .head0    (if_instr0),
        .head1    (if_instr1),
        .count    (q_count),
        .free     (q_free)
    );

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_stall_cnt <= '0;
            perf_flush_cnt       <= '0;
        end else begin
            if (id_ready && !if_instr0.valid && (perf_fetch_stall_cnt != '1))
                perf_fetch_stall_cnt <= perf_fetch_stall_cnt + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
